// File: rtl/led_step_ctrl.sv
// rtl/led_step_ctrl.sv - one-hot LED step sequencer with debounced run/pause button
module led_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_DIV        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic [1:0] mode,
  output logic [7:0] led,
  output logic       running,
  output logic       step
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} run_state_t;

  run_state_t    state;
  logic          sync1;
  logic          btn_s;
  logic          deb;
  logic          deb_d;
  logic          press;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] pre;
  logic          dir_right;

  assign running = (state == RUNNING);
  assign step    = running && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= button;
      btn_s <= sync1;
    end
  end

  // A change is accepted only after it has persisted DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      deb_d <= deb;
      press <= deb && !deb_d;
      if (btn_s != deb) begin
        if (deb_cnt == DEB_LAST) begin
          deb     <= btn_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PAUSED;
      pre   <= '0;
    end else begin
      case (state)
        PAUSED: begin
          pre <= '0;
          if (press) state <= RUNNING;
        end
        RUNNING: begin
          if (press) begin
            state <= PAUSED;
            pre   <= '0;
          end else begin
            pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
          end
        end
        default: state <= PAUSED;
      endcase
    end
  end

  // Bounce reflects at either end so each end value is shown for exactly one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led       <= 8'h01;
      dir_right <= 1'b0;
    end else if (step) begin
      case (mode)
        2'b00: led <= {led[6:0], led[7]};
        2'b01: led <= {led[0], led[7:1]};
        2'b10: begin
          if (!dir_right) begin
            if (led == 8'h80) begin
              dir_right <= 1'b1;
              led       <= 8'h40;
            end else begin
              led <= {led[6:0], 1'b0};
            end
          end else begin
            if (led == 8'h01) begin
              dir_right <= 1'b0;
              led       <= 8'h02;
            end else begin
              led <= {1'b0, led[7:1]};
            end
          end
        end
        default: led <= led;
      endcase
    end
  end

endmodule
